// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : digit_serial_addsub
//  Purpose  : Multi-cycle WIDTH-bit adder/subtractor that processes DIGIT bits
//             per clock. It computes a + b, or a - b as a + ~b + 1. A
//             start/busy/done handshake controls it. It reports the carry out
//             of the MSB and two's-complement overflow.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous, active-high reset
//             start  - request, sampled only while idle
//             a, b   - operands, captured when start is accepted
//             sub    - 0: a+b, 1: a-b, captured with the operands
//             busy   - high while an operation is in flight (RUN and DONE)
//             done   - one-cycle pulse when s/cout/ovf hold a new result
//             s      - result register
//             cout   - carry out of the MSB (subtract: 1 = no borrow)
//             ovf    - signed overflow
//  Config   : define ADDSUB_SAT_EN to clamp s to the signed limit on overflow
//  Revision : 1.0 - initial release
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NDIG = WIDTH / DIGIT;
    localparam int c_KW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    // r_acc starts as operand A. Each RUN cycle consumes its low digit and
    // shifts the new sum digit in at the top. After the last digit it holds
    // the complete sum, LSB digit lowest.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_bx;     // b ^ {WIDTH{sub}}, shifted right each cycle
    logic             r_carry;
    logic [c_KW-1:0]  r_k;

    logic [DIGIT:0]   w_dsum_ext;
    logic [DIGIT-1:0] w_digit;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_bx_next;
    logic [WIDTH-1:0] w_s_load;
    logic             w_last;
    logic             w_a_msb;
    logic             w_bx_msb;
    logic             w_ovf;

    assign w_dsum_ext  = {1'b0, r_acc[DIGIT-1:0]} + {1'b0, r_bx[DIGIT-1:0]}
                       + (DIGIT+1)'(r_carry);
    assign w_digit     = w_dsum_ext[DIGIT-1:0];
    assign w_carry_out = w_dsum_ext[DIGIT];
    assign w_last      = (r_k == c_KLAST);

    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_acc_next = w_digit;
            assign w_bx_next  = r_bx;
        end else begin : g_partial
            assign w_acc_next = {w_digit, r_acc[WIDTH-1:DIGIT]};
            assign w_bx_next  = {{DIGIT{1'b0}}, r_bx[WIDTH-1:DIGIT]};
        end
    endgenerate

    // On the last digit the low digits of r_acc and r_bx hold the top digit
    // of the original operands, so their MSBs are the operand sign bits.
    assign w_a_msb  = r_acc[DIGIT-1];
    assign w_bx_msb = r_bx[DIGIT-1];
    assign w_ovf    = (w_a_msb == w_bx_msb) && (w_digit[DIGIT-1] != w_a_msb);

`ifdef ADDSUB_SAT_EN
    assign w_s_load = !w_ovf ? w_acc_next
                    : (w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign w_s_load = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_bx    <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_acc   <= a;
                        r_bx    <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_bx    <= w_bx_next;
                    r_carry <= w_carry_out;
                    r_k     <= r_k + 1'b1;
                    if (w_last) begin
                        s       <= w_s_load;
                        cout    <= w_carry_out;
                        ovf     <= w_ovf;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
